// File: rtl/exec_mem_unit.sv
// RV32I single-cycle execute/memory stage: decode, ALU, branch/jump resolution, byte-addressed data memory.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing alignment.
module exec_mem_unit #(
    parameter int DMEM_WORDS = 256,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic [3:0]      alu_sel,
    output logic            rs2_imm_sel,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] wb_data,
    output logic            reg_wen,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal_instr,
    output logic            mem_err
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic       legal;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices are resolved upstream; only the decode fields matter here.
    assign unused_fields = ^instr[24:15];

    assign is_r      = (opcode == OP_R);
    assign is_imm    = (opcode == OP_IMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:      legal = (funct7 == 7'h00) ||
                               ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            OP_IMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == 7'h00);
                    3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
            end
            OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OP_STORE:  legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_JALR:   legal = (funct3 == 3'b000);
            OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    assign illegal_instr = ~legal;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_sel = ALU_ADD;
        if (is_r)           alu_sel = alu_from_f3(funct3, funct7[5]);
        else if (is_imm)    alu_sel = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        else if (is_branch) alu_sel = ALU_SUB;
        else if (is_lui)    alu_sel = ALU_PASS;
    end

    assign rs2_imm_sel = is_imm | is_load | is_store | is_jalr | is_lui | is_auipc;

    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      shamt;

    assign op_a  = is_auipc ? pc : rs1_data;
    assign op_b  = rs2_imm_sel ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        case (alu_sel)
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SRA:  alu_out = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:   alu_out = op_a | op_b;
            ALU_AND:  alu_out = op_a & op_b;
            ALU_PASS: alu_out = op_b;
            default:  alu_out = '0;
        endcase
    end

    logic            br_eq, br_lt, br_ltu, br_taken;
    logic [XLEN-1:0] pc_plus4, pc_plus_imm;

    assign br_eq       = (rs1_data == rs2_data);
    assign br_lt       = ($signed(rs1_data) < $signed(rs2_data));
    assign br_ltu      = (rs1_data < rs2_data);
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus_imm = pc + imm;

    always_comb begin
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = ~br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = ~br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = ~br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (legal) begin
            if (is_jal || (is_branch && br_taken)) next_pc = pc_plus_imm;
            else if (is_jalr)                      next_pc = alu_out & ~XLEN'(1);
        end
    end

    logic [31:0]   mem [DMEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    size, lane;
    logic          misaligned;
    logic [31:0]   rd_word, rd_shift, load_data, st_data;
    logic [3:0]    st_be;
    logic          st_en;

    assign word_idx = alu_out[AW+1:2];
    assign size     = funct3[1:0];

`ifdef MISALIGN_TRAP_EN
    assign lane       = alu_out[1:0];
    assign misaligned = legal && (is_load || is_store) &&
                        (((size == 2'b01) && alu_out[0]) || ((size == 2'b10) && (alu_out[1:0] != 2'b00)));
`else
    assign lane       = (size == 2'b10) ? 2'b00 : (size == 2'b01) ? {alu_out[1], 1'b0} : alu_out[1:0];
    assign misaligned = 1'b0;
`endif

    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_shift[7:0]};
            3'b101:  load_data = {16'h0, rd_shift[15:0]};
            default: load_data = '0;
        endcase
        if (misaligned) load_data = '0;
    end

    always_comb begin
        case (size)
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << lane;
                st_data = {2{rs2_data[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = rs2_data[31:0];
            end
        endcase
    end

    assign st_en = rst && legal && is_store && !misaligned;

    // Contents deliberately survive reset; only the write enable is gated by rst.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic mem_err_q, mem_err_d;

    assign mem_err_d = mem_err_q | misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_err_q <= 1'b0;
        else      mem_err_q <= mem_err_d;
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    always_comb begin
        if (is_load)                 wb_data = load_data;
        else if (is_jal || is_jalr)  wb_data = pc_plus4;
        else if (is_lui)             wb_data = imm;
        else if (is_auipc)           wb_data = pc_plus_imm;
        else                         wb_data = alu_out;
    end

    assign reg_wen = legal && (rd != 5'd0) && !is_store && !is_branch;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: vector table, hand-written memory/reset sequences, random vs. reference model.
module tb_exec_mem_unit;

    localparam int DMEM_WORDS = 256;
    localparam int ABITS      = $clog2(DMEM_WORDS) + 2;
    localparam int MBYTES     = DMEM_WORDS * 4;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111;
    localparam logic [6:0] LUI_OP  = 7'b0110111;
    localparam logic [6:0] AUI_OP  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rs1_data, rs2_data, imm;
    logic [3:0]  alu_sel;
    logic        rs2_imm_sel, reg_wen, illegal_instr, mem_err;
    logic [31:0] alu_out, wb_data, next_pc;

    always #5 clk = ~clk;

    exec_mem_unit #(.DMEM_WORDS(DMEM_WORDS), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .alu_sel(alu_sel), .rs2_imm_sel(rs2_imm_sel),
        .alu_out(alu_out), .wb_data(wb_data), .reg_wen(reg_wen), .next_pc(next_pc),
        .illegal_instr(illegal_instr), .mem_err(mem_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [MBYTES];

    typedef struct {
        string       name;
        logic [31:0] ins, pcv, a, b, im;
        logic [2:0]  mask;   // bit0 alu_out, bit1 wb_data, bit2 alu_sel/rs2_imm_sel
        logic [31:0] alu, wb;
        logic [3:0]  sel;
        logic        bsel, wen;
        logic [31:0] npc;
        logic        ill;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        @(negedge clk);
        instr = ins; pc = pcv; rs1_data = a; rs2_data = b; imm = im;
        #1;
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ins, pcv, a, b, im,
                           input logic [2:0] mask, input logic [31:0] alu, wb,
                           input logic [3:0] sel, input logic bsel, input logic wen,
                           input logic [31:0] npc, input logic ill);
        vec_t v;
        v.name = nm; v.ins = ins; v.pcv = pcv; v.a = a; v.b = b; v.im = im;
        v.mask = mask; v.alu = alu; v.wb = wb; v.sel = sel; v.bsel = bsel;
        v.wen = wen; v.npc = npc; v.ill = ill;
        vt.push_back(v);
    endtask

    // Reference ALU in plain arithmetic terms: f3 picks the operation, alt selects SUB/SRA.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a * (32'd1 << s);
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0)) : a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return slt;
            3'd5: return !slt;
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned p;
        logic [31:0] v;
        p = int'(addr % MBYTES);
        case (f3)
            3'd0: v = 32'($signed(mdl[p]));
            3'd1: v = 32'($signed({mdl[p+1], mdl[p]}));
            3'd2: v = {mdl[p+3], mdl[p+2], mdl[p+1], mdl[p]};
            3'd4: v = {24'h0, mdl[p]};
            default: v = {16'h0, mdl[p+1], mdl[p]};
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input int unsigned nbytes, input logic [31:0] d);
        int unsigned p;
        p = int'(addr % MBYTES);
        for (int unsigned k = 0; k < nbytes; k++) mdl[p+k] = d[8*k +: 8];
    endtask

    task automatic rand_one(input int it);
        logic [31:0] ins, pcv, a, b, im, e_wb, e_npc, addr, r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        e_wen, e_ill, chk_wb, is_st;
        int unsigned sz, kind;
        pcv = $urandom & ~32'd3; rd = 5'($urandom); a = $urandom; b = $urandom; im = $urandom;
        f7 = 7'h00; f3 = 3'($urandom); kind = $urandom_range(0, 9);
        e_npc = pcv + 32'd4; e_ill = 1'b0; e_wen = (rd != 5'd0); chk_wb = 1'b1; is_st = 1'b0;
        e_wb = '0; sz = 0; addr = '0;
        case (kind)
            0: begin
                if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
                ins = enc(f7, f3, rd, R_OP); e_wb = ref_alu(f3, f7[5], a, b);
            end
            1: begin
                r = $urandom;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    f7 = (f3 == 3'd5 && r[10]) ? 7'h20 : 7'h00;
                    im = {20'h0, f7, r[4:0]};
                end else begin
                    im = 32'($signed(r[11:0]));
                    f7 = im[11:5];
                end
                ins = enc(f7, f3, rd, I_OP); e_wb = ref_alu(f3, (f3 == 3'd5) && f7[5], a, im);
            end
            2: begin im = im & 32'hFFFF_F000; ins = enc(7'h0, f3, rd, LUI_OP); e_wb = im; end
            3: begin ins = enc(7'h0, f3, rd, AUI_OP); e_wb = pcv + im; end
            4: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                if ($urandom_range(0, 2) == 0) b = a;
                ins = enc(7'h0, f3, rd, BR_OP); e_wen = 1'b0; chk_wb = 1'b0;
                if (ref_taken(f3, a, b)) e_npc = pcv + im;
            end
            5: begin ins = enc(7'h0, f3, rd, JAL_OP); e_wb = pcv + 32'd4; e_npc = pcv + im; end
            6: begin ins = enc(7'h0, 3'd0, rd, JALR_OP); e_wb = pcv + 32'd4; e_npc = (a + im) & ~32'd1; end
            7, 8: begin
                sz   = $urandom_range(0, 2);
                addr = 32'($urandom_range(0, 63)) & ~((32'd1 << sz) - 32'd1);
                im   = 32'($urandom_range(0, 63)) - 32'd32;
                a    = addr - im + ($urandom << ABITS);
                if (kind == 7) begin
                    f3 = {(sz < 2) ? 1'($urandom_range(0, 1)) : 1'b0, 2'(sz)};
                    ins = enc(7'h0, f3, rd, LD_OP); e_wb = ref_load(addr, f3);
                end else begin
                    ins = enc(7'h0, 3'(sz), rd, ST_OP); e_wen = 1'b0; chk_wb = 1'b0; is_st = 1'b1;
                end
            end
            default: begin
                case ($urandom_range(0, 2))
                    0: ins = {25'h0, 7'h7F};
                    1: ins = enc(7'h0, 3'd3, rd, LD_OP);
                    default: ins = enc(7'h0, 3'd1, rd, JALR_OP);
                endcase
                e_ill = 1'b1; e_wen = 1'b0; chk_wb = 1'b0;
            end
        endcase
        apply(ins, pcv, a, b, im);
        chk($sformatf("rnd%0d_k%0d_ill", it, kind), illegal_instr, e_ill);
        chk($sformatf("rnd%0d_k%0d_wen", it, kind), reg_wen, e_wen);
        chk($sformatf("rnd%0d_k%0d_npc", it, kind), next_pc, e_npc);
        if (chk_wb) chk($sformatf("rnd%0d_k%0d_wb", it, kind), wb_data, e_wb);
        if (is_st) ref_store(addr, 32'd1 << sz, b);
    endtask

    localparam logic [31:0] NOP = {25'h0, 7'b0010011};
    localparam logic [31:0] SW  = {17'h0, 3'b010, 5'h0, 7'b0100011};
    localparam logic [31:0] LW  = {17'h0, 3'b010, 5'h5, 7'b0000011};

    initial begin
        rst = 1'b0; instr = NOP; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;

        // Reset: stores suppressed, mem_err held low, memory contents kept.
        repeat (2) @(negedge clk);
        #1 chk("rst_mem_err", mem_err, 32'd0);
        rst = 1'b1;
        apply(SW, 0, 0, 32'h0, 0);
        apply(NOP, 0, 0, 0, 0);
        rst = 1'b0;
        apply(SW, 0, 0, 32'hDEADBEEF, 0);
        apply(LW, 0, 0, 0, 0);
        chk("rst_store_blocked", wb_data, 32'h0);
        chk("rst_mem_err_hold", mem_err, 32'd0);
        rst = 1'b1;
        apply(SW, 0, 0, 32'hDEADBEEF, 0);
        apply(LW, 0, 0, 0, 0);
        chk("post_rst_lw", wb_data, 32'hDEADBEEF);

        add_vec("add",    enc(7'h00,3'd0,5'd3,R_OP), 0, 7, 5, 0,              3'b111, 12, 12, 4'd0, 0, 1, 4, 0);
        add_vec("sub",    enc(7'h20,3'd0,5'd3,R_OP), 0, 5, 7, 0,              3'b111, 32'hFFFFFFFE, 32'hFFFFFFFE, 4'd1, 0, 1, 4, 0);
        add_vec("sra",    enc(7'h20,3'd5,5'd3,R_OP), 0, 32'h80000000, 4, 0,   3'b111, 32'hF8000000, 32'hF8000000, 4'd7, 0, 1, 4, 0);
        add_vec("sltu",   enc(7'h00,3'd3,5'd3,R_OP), 0, 32'hFFFFFFFF, 1, 0,   3'b111, 0, 0, 4'd4, 0, 1, 4, 0);
        add_vec("slt",    enc(7'h00,3'd2,5'd3,R_OP), 0, 32'hFFFFFFFF, 1, 0,   3'b111, 1, 1, 4'd3, 0, 1, 4, 0);
        add_vec("xori",   enc(7'h00,3'd4,5'd4,I_OP), 0, 32'hF0F0, 32'h12345, 32'hFF, 3'b111, 32'hF00F, 32'hF00F, 4'd5, 1, 1, 4, 0);
        add_vec("srai",   enc(7'h20,3'd5,5'd4,I_OP), 0, 32'h80000000, 0, 32'h404, 3'b111, 32'hF8000000, 32'hF8000000, 4'd7, 1, 1, 4, 0);
        add_vec("beq_t",  enc(7'h00,3'd0,5'd0,BR_OP), 32'h100, 5, 5, 32'h20,  3'b000, 0, 0, 0, 0, 0, 32'h120, 0);
        add_vec("beq_nt", enc(7'h00,3'd0,5'd0,BR_OP), 32'h100, 5, 6, 32'h20,  3'b000, 0, 0, 0, 0, 0, 32'h104, 0);
        add_vec("bltu",   enc(7'h00,3'd6,5'd0,BR_OP), 32'h100, 1, 32'hFFFFFFFF, 32'h20, 3'b000, 0, 0, 0, 0, 0, 32'h120, 0);
        add_vec("blt",    enc(7'h00,3'd4,5'd0,BR_OP), 32'h100, 1, 32'hFFFFFFFF, 32'h20, 3'b000, 0, 0, 0, 0, 0, 32'h104, 0);
        add_vec("jal",    enc(7'h00,3'd0,5'd1,JAL_OP), 32'h100, 0, 0, 32'h20, 3'b010, 0, 32'h104, 0, 0, 1, 32'h120, 0);
        add_vec("jalr",   enc(7'h00,3'd0,5'd1,JALR_OP), 32'h100, 32'h203, 0, 0, 3'b110, 0, 32'h104, 4'd0, 1, 1, 32'h202, 0);
        add_vec("lui",    enc(7'h00,3'd0,5'd5,LUI_OP), 0, 0, 0, 32'h12345000, 3'b111, 32'h12345000, 32'h12345000, 4'd10, 1, 1, 4, 0);
        add_vec("auipc",  enc(7'h00,3'd0,5'd5,AUI_OP), 32'h100, 0, 0, 32'h12345000, 3'b111, 32'h12345100, 32'h12345100, 4'd0, 1, 1, 32'h104, 0);
        add_vec("rd_x0",  enc(7'h00,3'd0,5'd0,R_OP), 0, 7, 5, 0,              3'b001, 12, 0, 0, 0, 0, 4, 0);
        add_vec("ill_op", {25'h0, 7'h7F}, 32'h100, 0, 0, 0,                   3'b000, 0, 0, 0, 0, 0, 32'h104, 1);
        add_vec("ill_r",  enc(7'h20,3'd1,5'd3,R_OP), 0, 1, 1, 0,              3'b000, 0, 0, 0, 0, 0, 4, 1);
        add_vec("ill_sl", enc(7'h20,3'd1,5'd3,I_OP), 0, 1, 0, 32'h401,        3'b000, 0, 0, 0, 0, 0, 4, 1);

        foreach (vt[i]) begin
            apply(vt[i].ins, vt[i].pcv, vt[i].a, vt[i].b, vt[i].im);
            chk({vt[i].name, "_ill"}, illegal_instr, vt[i].ill);
            chk({vt[i].name, "_wen"}, reg_wen, vt[i].wen);
            chk({vt[i].name, "_npc"}, next_pc, vt[i].npc);
            if (vt[i].mask[0]) chk({vt[i].name, "_alu"}, alu_out, vt[i].alu);
            if (vt[i].mask[1]) chk({vt[i].name, "_wb"}, wb_data, vt[i].wb);
            if (vt[i].mask[2]) begin
                chk({vt[i].name, "_sel"}, alu_sel, vt[i].sel);
                chk({vt[i].name, "_bsel"}, rs2_imm_sel, vt[i].bsel);
            end
        end

        // Byte/halfword lanes and sign/zero extension.
        apply(SW, 0, 32'h10, 32'h11223344, 0);
        apply(enc(7'h0,3'd0,5'd5,LD_OP), 0, 32'h13, 0, 0);
        chk("lb_13", wb_data, 32'h00000011);
        chk("lb_13_wen", reg_wen, 32'd1);
        apply(enc(7'h0,3'd0,5'd0,ST_OP), 0, 32'h11, 32'h80, 0);
        apply(enc(7'h0,3'd0,5'd5,LD_OP), 0, 32'h11, 0, 0);
        chk("lb_11", wb_data, 32'hFFFFFF80);
        apply(enc(7'h0,3'd4,5'd5,LD_OP), 0, 32'h11, 0, 0);
        chk("lbu_11", wb_data, 32'h00000080);
        apply(enc(7'h0,3'd1,5'd5,LD_OP), 0, 32'h12, 0, 0);
        chk("lh_12", wb_data, 32'h00001122);
        apply(LW, 0, 32'h10, 0, 0);
        chk("lw_10", wb_data, 32'h11228044);

        // Misaligned word store at 0x22.
        apply(SW, 0, 32'h20, 32'h0, 0);
        apply(SW, 0, 32'h22, 32'hCAFEF00D, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err_pre", mem_err, 32'd0);
        apply(LW, 0, 32'h20, 0, 0);
        chk("mis_st_blocked", wb_data, 32'h0);
        chk("mis_err_set", mem_err, 32'd1);
        apply(enc(7'h0,3'd1,5'd5,LD_OP), 0, 32'h21, 0, 0);
        chk("mis_ld_zero", wb_data, 32'h0);
        chk("mis_ld_wen", reg_wen, 32'd1);
        apply(NOP, 0, 0, 0, 0);
        apply(NOP, 0, 0, 0, 0);
        chk("mis_err_sticky", mem_err, 32'd1);
        rst = 1'b0;
        #1 chk("mis_err_rst", mem_err, 32'd0);
        rst = 1'b1;
`else
        apply(LW, 0, 32'h20, 0, 0);
        chk("mis_st_aligned", wb_data, 32'hCAFEF00D);
        chk("mis_err_tied", mem_err, 32'd0);
        apply(enc(7'h0,3'd1,5'd5,LD_OP), 0, 32'h21, 0, 0);
        chk("mis_lh_aligned", wb_data, 32'hFFFFF00D);
`endif

        // Random phase: seed the low 64 bytes, then mixed instructions against the model.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            apply(SW, 0, 32'(w * 4), d, 0);
            ref_store(32'(w * 4), 4, d);
        end
        for (int it = 0; it < 400; it++) rand_one(it);
        apply(NOP, 0, 0, 0, 0);
        chk("rnd_mem_err", mem_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
